// File: rtl/sd_spi_responder_if.sv
// Host-side bus of sd_spi_responder: deframed SD commands, raw received bytes and
// the one-byte reply handshake toward the card-emulation logic.
interface sd_spi_responder_if;
    logic        CMD_VALID;
    logic [5:0]  CMD_INDEX;
    logic [31:0] CMD_ARG;
    logic        CMD_CRC_ERR;
    logic [7:0]  RX_BYTE;
    logic        RX_STROBE;
    logic [7:0]  TX_BYTE;
    logic        TX_VALID;
    logic        TX_READY;

    modport slave (
        output CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC_ERR, RX_BYTE, RX_STROBE, TX_READY,
        input  TX_BYTE, TX_VALID
    );

    modport master (
        input  CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC_ERR, RX_BYTE, RX_STROBE, TX_READY,
        output TX_BYTE, TX_VALID
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card target: oversampled mode-0 SPI slave with 6-byte command deframer.
// Optional macro SD_CRC_CHECK_EN enables CRC7 checking of each command frame.
module sd_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic CLOCK_50,
    input  logic nRESET,
    input  logic SPI_CLK,
    input  logic SPI_MOSI,
    input  logic SPI_CS,
    output logic SPI_MISO,
    output logic SPI_MISO_OE,
    sd_spi_responder_if.slave host
);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_ARG0 = 3'd1,
        ST_ARG1 = 3'd2,
        ST_ARG2 = 3'd3,
        ST_ARG3 = 3'd4,
        ST_CRC  = 3'd5
    } frame_state_t;

`ifdef SD_CRC_CHECK_EN
    function automatic logic [6:0] crc7_update(input logic [6:0] crc_in, input logic [7:0] data_in);
        logic [6:0] crc_v;
        logic       fb_v;
        crc_v = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb_v  = crc_v[6] ^ data_in[i];
            crc_v = {crc_v[5:0], 1'b0};
            if (fb_v) begin
                crc_v = crc_v ^ 7'h09;
            end
        end
        return crc_v;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   sck_d_r;
    logic                   cs_d_r;

    logic       sck_s, mosi_s, cs_s;
    logic       cs_fall_s, cs_rise_s, sck_rise_s, sck_fall_s;
    logic       byte_end_s, reload_s, tx_load_s;
    logic [7:0] reload_val_s;

    logic [2:0] bit_cnt_r;
    logic [6:0] rx_shift_r;
    logic [7:0] rx_byte_r;
    logic       rx_strobe_r;
    logic [6:0] tx_r;
    logic       miso_r;
    logic       miso_oe_r;
    logic [7:0] hold_r;
    logic       tx_ready_r;

    frame_state_t state_r, state_nxt_s;
    logic [5:0]   idx_r, idx_nxt_s;
    logic [31:0]  arg_r, arg_nxt_s;
    logic [5:0]   cmd_index_r, cmd_index_nxt_s;
    logic [31:0]  cmd_arg_r, cmd_arg_nxt_s;
    logic         cmd_valid_r, cmd_valid_nxt_s;
    logic         crc_err_r, crc_err_nxt_s;
`ifdef SD_CRC_CHECK_EN
    logic [6:0]   crc_r, crc_nxt_s;
`endif

    // Input synchronizers plus one delayed copy of SCK and CS for edge detection
    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sck_d_r     <= 1'b0;
            cs_d_r      <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SPI_CLK};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPI_CS};
            sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
            cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sck_s  = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    assign cs_s   = cs_sync_r[SYNC_STAGES-1];

    // SCK edges only count while CS has been low for both the current and previous sample
    assign cs_fall_s    = cs_d_r & ~cs_s;
    assign cs_rise_s    = ~cs_d_r & cs_s;
    assign sck_rise_s   = ~cs_s & ~cs_d_r & sck_s & ~sck_d_r;
    assign sck_fall_s   = ~cs_s & ~cs_d_r & ~sck_s & sck_d_r;
    assign byte_end_s   = sck_fall_s & (bit_cnt_r == 3'd0);
    assign reload_s     = cs_fall_s | byte_end_s;
    assign reload_val_s = tx_ready_r ? FILL_BYTE : hold_r;
    assign tx_load_s    = host.TX_VALID & tx_ready_r;

    // Bit-level shifting; miso_r is the MSB of the outgoing byte, tx_r the remaining bits
    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            bit_cnt_r   <= 3'd0;
            rx_shift_r  <= 7'd0;
            rx_byte_r   <= 8'd0;
            rx_strobe_r <= 1'b0;
            tx_r        <= FILL_BYTE[6:0];
            miso_r      <= 1'b1;
            miso_oe_r   <= 1'b0;
        end else begin
            rx_strobe_r <= 1'b0;
            if (cs_rise_s) begin
                miso_oe_r  <= 1'b0;
                miso_r     <= 1'b1;
                bit_cnt_r  <= 3'd0;
                rx_shift_r <= 7'd0;
            end else if (cs_fall_s) begin
                miso_oe_r  <= 1'b1;
                bit_cnt_r  <= 3'd0;
                rx_shift_r <= 7'd0;
                miso_r     <= reload_val_s[7];
                tx_r       <= reload_val_s[6:0];
            end else if (sck_rise_s) begin
                rx_shift_r <= {rx_shift_r[5:0], mosi_s};
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    rx_byte_r   <= {rx_shift_r, mosi_s};
                    rx_strobe_r <= 1'b1;
                end
            end else if (byte_end_s) begin
                miso_r <= reload_val_s[7];
                tx_r   <= reload_val_s[6:0];
            end else if (sck_fall_s) begin
                miso_r <= tx_r[6];
                tx_r   <= {tx_r[5:0], 1'b1};
            end
        end
    end

    // Holding register: a load in the reload cycle lands after the reload has sampled it
    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            hold_r     <= 8'd0;
            tx_ready_r <= 1'b1;
        end else if (cs_rise_s) begin
            tx_ready_r <= 1'b1;
        end else if (tx_load_s) begin
            hold_r     <= host.TX_BYTE;
            tx_ready_r <= 1'b0;
        end else if (reload_s && !tx_ready_r) begin
            tx_ready_r <= 1'b1;
        end
    end

    // Framer next-state: consumes each completed byte the cycle after its strobe
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        arg_nxt_s       = arg_r;
        cmd_index_nxt_s = cmd_index_r;
        cmd_arg_nxt_s   = cmd_arg_r;
        cmd_valid_nxt_s = 1'b0;
        crc_err_nxt_s   = 1'b0;
`ifdef SD_CRC_CHECK_EN
        crc_nxt_s       = crc_r;
`endif
        if (cs_rise_s) begin
            state_nxt_s = ST_HUNT;
        end else if (rx_strobe_r) begin
`ifdef SD_CRC_CHECK_EN
            crc_nxt_s = crc7_update((state_r == ST_HUNT) ? 7'd0 : crc_r, rx_byte_r);
`endif
            case (state_r)
                ST_HUNT: begin
                    if (rx_byte_r[7:6] == 2'b01) begin
                        idx_nxt_s   = rx_byte_r[5:0];
                        state_nxt_s = ST_ARG0;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_ARG0: begin
                    arg_nxt_s   = {arg_r[23:0], rx_byte_r};
                    state_nxt_s = ST_ARG1;
                end
                ST_ARG1: begin
                    arg_nxt_s   = {arg_r[23:0], rx_byte_r};
                    state_nxt_s = ST_ARG2;
                end
                ST_ARG2: begin
                    arg_nxt_s   = {arg_r[23:0], rx_byte_r};
                    state_nxt_s = ST_ARG3;
                end
                ST_ARG3: begin
                    arg_nxt_s   = {arg_r[23:0], rx_byte_r};
                    state_nxt_s = ST_CRC;
                end
                ST_CRC: begin
                    state_nxt_s = ST_HUNT;
`ifdef SD_CRC_CHECK_EN
                    if (rx_byte_r == {crc_r, 1'b1}) begin
                        cmd_index_nxt_s = idx_r;
                        cmd_arg_nxt_s   = arg_r;
                        cmd_valid_nxt_s = 1'b1;
                    end else begin
                        crc_err_nxt_s   = 1'b1;
                    end
`else
                    cmd_index_nxt_s = idx_r;
                    cmd_arg_nxt_s   = arg_r;
                    cmd_valid_nxt_s = 1'b1;
`endif
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Framer state and command output registers
    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            state_r     <= ST_HUNT;
            idx_r       <= 6'd0;
            arg_r       <= 32'd0;
            cmd_index_r <= 6'd0;
            cmd_arg_r   <= 32'd0;
            cmd_valid_r <= 1'b0;
            crc_err_r   <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            crc_r       <= 7'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            arg_r       <= arg_nxt_s;
            cmd_index_r <= cmd_index_nxt_s;
            cmd_arg_r   <= cmd_arg_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
            crc_err_r   <= crc_err_nxt_s;
`ifdef SD_CRC_CHECK_EN
            crc_r       <= crc_nxt_s;
`endif
        end
    end

    assign SPI_MISO         = miso_r;
    assign SPI_MISO_OE      = miso_oe_r;
    assign host.CMD_VALID   = cmd_valid_r;
    assign host.CMD_INDEX   = cmd_index_r;
    assign host.CMD_ARG     = cmd_arg_r;
    assign host.CMD_CRC_ERR = crc_err_r;
    assign host.RX_BYTE     = rx_byte_r;
    assign host.RX_STROBE   = rx_strobe_r;
    assign host.TX_READY    = tx_ready_r;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: acts as the SPI master and the card-emulation host.
module tb_sd_spi_responder;

    logic CLOCK_50 = 1'b0;
    logic nRESET, SPI_CLK, SPI_MOSI, SPI_CS;
    logic SPI_MISO, SPI_MISO_OE;

    sd_spi_responder_if bus();

    sd_spi_responder #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
        .CLOCK_50   (CLOCK_50),
        .nRESET     (nRESET),
        .SPI_CLK    (SPI_CLK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_CS     (SPI_CS),
        .SPI_MISO   (SPI_MISO),
        .SPI_MISO_OE(SPI_MISO_OE),
        .host       (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int valid_cnt = 0;
    int crcerr_cnt = 0;
    int seq_err = 0;
    logic prev_strobe = 1'b0;
    int s0, v0, e0;
    logic [7:0] rxb;

    // Pulse counters; a command result must directly follow a byte strobe
    always @(negedge CLOCK_50) begin
        if (bus.RX_STROBE) strobe_cnt++;
        if (bus.CMD_VALID) valid_cnt++;
        if (bus.CMD_CRC_ERR) crcerr_cnt++;
        if ((bus.CMD_VALID || bus.CMD_CRC_ERR) && !prev_strobe) seq_err++;
        prev_strobe = bus.RX_STROBE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode-0 transfer of nbits; optionally offers a reply byte at the byte-end reload cycle
    task automatic xfer(input logic [7:0] tx, input int nbits, input int half,
                        input logic offer, input logic [7:0] offer_b, output logic [7:0] rx);
        logic done;
        rx = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = tx[7-i];
            repeat (half) @(negedge CLOCK_50);
            rx = {rx[6:0], SPI_MISO};
            SPI_CLK = 1'b1;
            repeat (half) @(negedge CLOCK_50);
            SPI_CLK = 1'b0;
        end
        if (offer) begin
            repeat (2) @(negedge CLOCK_50);
            bus.TX_BYTE  = offer_b;
            bus.TX_VALID = 1'b1;
            done = 1'b0;
            for (int k = 0; k < 32 && !done; k++) begin
                if (bus.TX_READY) done = 1'b1;
                @(negedge CLOCK_50);
            end
            bus.TX_VALID = 1'b0;
            check("tx_offer_accepted", {31'd0, done}, 32'd1);
        end
    endtask

    task automatic send_seq(input logic [63:0] seq, input int n, input int half,
                            input logic chk, input logic [7:0] exp_miso);
        logic [7:0] r;
        for (int i = 0; i < n; i++) begin
            xfer(seq[8*(n-1-i) +: 8], 8, half, 1'b0, 8'h00, r);
            if (chk) check("miso_byte", {24'd0, r}, {24'd0, exp_miso});
        end
    endtask

    task automatic cs_set(input logic v);
        SPI_CS = v;
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic snap();
        s0 = strobe_cnt;
        v0 = valid_cnt;
        e0 = crcerr_cnt;
    endtask

    initial begin
        nRESET = 1'b0; SPI_CLK = 1'b0; SPI_MOSI = 1'b1; SPI_CS = 1'b1;
        bus.TX_BYTE = 8'h00; bus.TX_VALID = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_miso", {31'd0, SPI_MISO}, 32'd1);
        check("rst_oe", {31'd0, SPI_MISO_OE}, 32'd0);
        check("rst_valid", {31'd0, bus.CMD_VALID}, 32'd0);
        check("rst_crcerr", {31'd0, bus.CMD_CRC_ERR}, 32'd0);
        check("rst_strobe", {31'd0, bus.RX_STROBE}, 32'd0);
        check("rst_ready", {31'd0, bus.TX_READY}, 32'd1);
        check("rst_index", {26'd0, bus.CMD_INDEX}, 32'd0);
        check("rst_arg", bus.CMD_ARG, 32'd0);
        check("rst_rxbyte", {24'd0, bus.RX_BYTE}, 32'd0);
        nRESET = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // CMD0 frame, MISO idles at FF
        cs_set(1'b0);
        check("t1_oe_low_cs", {31'd0, SPI_MISO_OE}, 32'd1);
        snap();
        send_seq(64'h0000_4000_0000_0095, 6, 4, 1'b1, 8'hFF);
        repeat (6) @(negedge CLOCK_50);
        check("t1_valid_cnt", valid_cnt - v0, 32'd1);
        check("t1_strobes", strobe_cnt - s0, 32'd6);
        check("t1_index", {26'd0, bus.CMD_INDEX}, 32'd0);
        check("t1_arg", bus.CMD_ARG, 32'd0);
        check("t1_crcerr", crcerr_cnt - e0, 32'd0);

        // Reply byte pushed while deselected goes out first after selection
        cs_set(1'b1);
        check("t2_oe_cs_high", {31'd0, SPI_MISO_OE}, 32'd0);
        bus.TX_BYTE = 8'h01; bus.TX_VALID = 1'b1;
        @(negedge CLOCK_50);
        bus.TX_VALID = 1'b0;
        check("t2_ready_busy", {31'd0, bus.TX_READY}, 32'd0);
        cs_set(1'b0);
        check("t2_ready_back", {31'd0, bus.TX_READY}, 32'd1);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, rxb);
        check("t2_miso_01", {24'd0, rxb}, 32'h01);
        send_seq(64'hFFFF, 2, 4, 1'b1, 8'hFF);

        // 12.5 MHz SCK, leading idle bytes ignored
        snap();
        send_seq(64'hFFFF_5100_0012_34FF, 8, 2, 1'b0, 8'h00);
        repeat (6) @(negedge CLOCK_50);
        check("t3_strobes", strobe_cnt - s0, 32'd8);
        check("t3_rxbyte", {24'd0, bus.RX_BYTE}, 32'hFF);
`ifdef SD_CRC_CHECK_EN
        check("t3_valid_cnt", valid_cnt - v0, 32'd0);
        check("t3_crcerr", crcerr_cnt - e0, 32'd1);
        check("t3_index", {26'd0, bus.CMD_INDEX}, 32'd0);
`else
        check("t3_valid_cnt", valid_cnt - v0, 32'd1);
        check("t3_index", {26'd0, bus.CMD_INDEX}, 32'd17);
        check("t3_arg", bus.CMD_ARG, 32'h0000_1234);
`endif

        // Partial byte aborted by CS high, then a full frame
        cs_set(1'b1);
        cs_set(1'b0);
        snap();
        xfer(8'h40, 3, 4, 1'b0, 8'h00, rxb);
        cs_set(1'b1);
        check("t4_oe_cs_high", {31'd0, SPI_MISO_OE}, 32'd0);
        check("t4_miso_cs_high", {31'd0, SPI_MISO}, 32'd1);
        check("t4_no_partial_strobe", strobe_cnt - s0, 32'd0);
        cs_set(1'b0);
        send_seq(64'h0000_4000_0000_0095, 6, 4, 1'b0, 8'h00);
        repeat (6) @(negedge CLOCK_50);
        check("t4_valid_cnt", valid_cnt - v0, 32'd1);
        check("t4_strobes", strobe_cnt - s0, 32'd6);

        // Bad CRC byte 0x94 on CMD0
        snap();
        send_seq(64'h0000_4000_0000_0094, 6, 4, 1'b0, 8'h00);
        repeat (6) @(negedge CLOCK_50);
`ifdef SD_CRC_CHECK_EN
        check("t5_crcerr", crcerr_cnt - e0, 32'd1);
        check("t5_no_valid", valid_cnt - v0, 32'd0);
        snap();
        send_seq(64'h0000_4000_0000_0095, 6, 4, 1'b0, 8'h00);
        repeat (6) @(negedge CLOCK_50);
        check("t5_good_valid", valid_cnt - v0, 32'd1);
`else
        check("t5_valid_ignores_crc", valid_cnt - v0, 32'd1);
        check("t5_crcerr_tied", crcerr_cnt - e0, 32'd0);
`endif
        check("seq_valid_after_strobe", seq_err, 32'd0);

        // FE queued, AA offered at reload while full, 5A offered at reload while empty
        bus.TX_BYTE = 8'hFE; bus.TX_VALID = 1'b1;
        @(negedge CLOCK_50);
        bus.TX_VALID = 1'b0;
        xfer(8'hFF, 8, 4, 1'b1, 8'hAA, rxb);
        check("t6_b1_fill", {24'd0, rxb}, 32'hFF);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, rxb);
        check("t6_b2_fe", {24'd0, rxb}, 32'hFE);
        xfer(8'hFF, 8, 4, 1'b1, 8'h5A, rxb);
        check("t6_b3_aa", {24'd0, rxb}, 32'hAA);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, rxb);
        check("t6_b4_fill", {24'd0, rxb}, 32'hFF);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, rxb);
        check("t6_b5_5a", {24'd0, rxb}, 32'h5A);
        xfer(8'hFF, 8, 4, 1'b0, 8'h00, rxb);
        check("t6_b6_fill", {24'd0, rxb}, 32'hFF);
        check("t6_ready", {31'd0, bus.TX_READY}, 32'd1);

        // Reset mid-byte takes effect immediately
        xfer(8'h00, 4, 4, 1'b0, 8'h00, rxb);
        nRESET = 1'b0;
        #1;
        check("t7_rst_oe", {31'd0, SPI_MISO_OE}, 32'd0);
        check("t7_rst_miso", {31'd0, SPI_MISO}, 32'd1);
        check("t7_rst_rxbyte", {24'd0, bus.RX_BYTE}, 32'd0);
        check("t7_rst_ready", {31'd0, bus.TX_READY}, 32'd1);
        SPI_CS = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        nRESET = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        check("t7_oe_after_rst", {31'd0, SPI_MISO_OE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
